// File: rtl/snoop_bus_pkg.sv
// Shared types and helpers for the snooping-bus arbiter.
//   bus_op_t    : snoop bus operation encoding (BusNoN is the idle/no-op value)
//   arb_state_t : arbiter FSM states
//   OWNER_W     : width of the owner index (enough for up to 8 cores)
//   wrap_inc    : modulo-n increment used to move the round-robin pointer
package snoop_bus_pkg;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_UPGR = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_NON  = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } arb_state_t;

  localparam int OWNER_W = 3;

  // (idx + 1) mod n, for idx in [0, n-1]
  function automatic logic [OWNER_W-1:0] wrap_inc(input logic [OWNER_W-1:0] idx,
                                                  input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + OWNER_W'(1);
  endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first requester at or after ptr_i, wrapping modulo NUM_CORES.
// Ports:
//   req_i    in  NUM_CORES  request vector
//   ptr_i    in  OWNER_W    round-robin pointer (highest-priority index)
//   winner_o out OWNER_W    index of the selected requester
//   valid_o  out 1          at least one request is present
module rr_pick
  import snoop_bus_pkg::*;
#(
  parameter int NUM_CORES = 2
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [OWNER_W-1:0]   ptr_i,
  output logic [OWNER_W-1:0]   winner_o,
  output logic                 valid_o
);

  logic [NUM_CORES-1:0] rot;
  logic [OWNER_W-1:0]   off;
  logic [OWNER_W:0]     sum;

  always_comb begin
    // Rotate so bit k of rot is request (ptr + k) mod NUM_CORES.
    rot     = NUM_CORES'({req_i, req_i} >> ptr_i);
    off     = '0;
    valid_o = 1'b0;
    // Walk downward so the smallest offset from the pointer wins.
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off     = OWNER_W'(k);
        valid_o = 1'b1;
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (OWNER_W+1)'(NUM_CORES)) sum = sum - (OWNER_W+1)'(NUM_CORES);
    winner_o = sum[OWNER_W-1:0];
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin owner selection for the shared snooping bus.
// A core keeps the bus for as long as it holds its request; every release is
// followed by exactly one dead (turnaround) cycle before the next grant.
// Optional feature macro: ARB_TIMEOUT_EN -- bounds a tenure to MAX_TENURE
// cycles and pulses tenure_expired on a forced release.
// Ports:
//   clk              in   1             rising-edge clock
//   reset            in   1             asynchronous active-low reset
//   req_core         in   NUM_CORES     per-core level request
//   bus_operation_in in   2*NUM_CORES   per-core bus op
//   bus_address_in   in   32*NUM_CORES  per-core address
//   bus_data_in      in   32*NUM_CORES  per-core data
//   cache_hit_in     in   NUM_CORES     per-core snoop hit
//   grant            out  NUM_CORES     registered one-hot grant
//   bus_operation_bc out  2             broadcast op (BusNoN when no owner)
//   bus_address_bc   out  32            broadcast address
//   bus_data_bc      out  32            broadcast data
//   owner_id         out  3             current owner index (valid while grant != 0)
//   cache_hit_bc     out  NUM_CORES     snoop hits with the owner's own bit masked
//   tenure_expired   out  1             one-cycle pulse on forced release
module snoop_bus_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int MAX_TENURE = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CORES-1:0]    req_core,
  input  logic [2*NUM_CORES-1:0]  bus_operation_in,
  input  logic [32*NUM_CORES-1:0] bus_address_in,
  input  logic [32*NUM_CORES-1:0] bus_data_in,
  input  logic [NUM_CORES-1:0]    cache_hit_in,
  output logic [NUM_CORES-1:0]    grant,
  output logic [1:0]              bus_operation_bc,
  output logic [31:0]             bus_address_bc,
  output logic [31:0]             bus_data_bc,
  output logic [OWNER_W-1:0]      owner_id,
  output logic [NUM_CORES-1:0]    cache_hit_bc,
  output logic                    tenure_expired
);

  arb_state_t           state_q, state_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [OWNER_W-1:0]   pick_idx;
  logic                 pick_vld;
  logic                 owner_req;
  logic                 force_rel;

  bus_op_t              op_sel;
  logic [31:0]          addr_sel;
  logic [31:0]          data_sel;

  rr_pick #(
    .NUM_CORES (NUM_CORES)
  ) u_rr_pick (
    .req_i    (req_core),
    .ptr_i    (rr_ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_vld)
  );

  // grant_q is one-hot, so this is the owner's own request.
  assign owner_req = |(req_core & grant_q);

`ifdef ARB_TIMEOUT_EN
  localparam logic [4:0] TENURE_LAST = 5'(MAX_TENURE - 1);

  logic [4:0] tenure_q, tenure_d;
  logic       expired_q, expired_d;

  // Counter reads 0 in the first granted cycle and is held at 0 elsewhere.
  assign tenure_d  = (state_q == GRANT) ? tenure_q + 5'd1 : 5'd0;
  assign force_rel = (state_q == GRANT) && (tenure_q == TENURE_LAST);
  // Only a release that overrides a still-held request counts as expiry.
  assign expired_d = force_rel && owner_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tenure_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      tenure_q  <= tenure_d;
      expired_q <= expired_d;
    end
  end

  assign tenure_expired = expired_q;
`else
  logic unused_max_tenure;

  assign unused_max_tenure = ^MAX_TENURE;
  assign force_rel         = 1'b0;
  assign tenure_expired    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          grant_d = NUM_CORES'(1) << pick_idx;
          owner_d = pick_idx;
        end
      end
      GRANT: begin
        if (!owner_req || force_rel) begin
          state_d  = RELEASE;
          grant_d  = '0;
          rr_ptr_d = wrap_inc(owner_q, NUM_CORES);
        end
      end
      RELEASE: begin
        // Arbitration here already sees the advanced pointer.
        if (pick_vld) begin
          state_d = GRANT;
          grant_d = NUM_CORES'(1) << pick_idx;
          owner_d = pick_idx;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Broadcast mux driven from the registered owner; BusNoN when nobody owns the bus.
  always_comb begin
    op_sel   = BUS_NON;
    addr_sel = '0;
    data_sel = '0;
    if (state_q == GRANT) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (owner_q == OWNER_W'(k)) begin
          op_sel   = bus_op_t'(bus_operation_in[2*k +: 2]);
          addr_sel = bus_address_in[32*k +: 32];
          data_sel = bus_data_in[32*k +: 32];
        end
      end
    end
  end

  assign grant            = grant_q;
  assign owner_id         = owner_q;
  assign bus_operation_bc = op_sel;
  assign bus_address_bc   = addr_sel;
  assign bus_data_bc      = data_sel;
  // The owner must not see its own snoop hit.
  assign cache_hit_bc     = cache_hit_in & ~grant_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
module tb_snoop_bus_arbiter;

  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    req_core = '0;
  logic [7:0]    bus_operation_in = '0;
  logic [127:0]  bus_address_in = '0;
  logic [127:0]  bus_data_in = '0;
  logic [3:0]    cache_hit_in = '0;
  logic [3:0]    grant;
  logic [1:0]    bus_operation_bc;
  logic [31:0]   bus_address_bc;
  logic [31:0]   bus_data_bc;
  logic [2:0]    owner_id;
  logic [3:0]    cache_hit_bc;
  logic          tenure_expired;

  snoop_bus_arbiter #(
    .NUM_CORES  (NC),
    .MAX_TENURE (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_core         (req_core),
    .bus_operation_in (bus_operation_in),
    .bus_address_in   (bus_address_in),
    .bus_data_in      (bus_data_in),
    .cache_hit_in     (cache_hit_in),
    .grant            (grant),
    .bus_operation_bc (bus_operation_bc),
    .bus_address_bc   (bus_address_bc),
    .bus_data_bc      (bus_data_bc),
    .owner_id         (owner_id),
    .cache_hit_bc     (cache_hit_bc),
    .tenure_expired   (tenure_expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  grant;
    logic [2:0]  owner;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  hit;
    int          len;
    int          gap;
    logic        expd;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic mon_in_ten = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [3:0] g, input logic [2:0] o, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] h,
                      input int len, input int gap, input logic e);
    exp_t r;
    r.grant = g; r.owner = o; r.op = op; r.addr = a; r.data = d; r.hit = h;
    r.len = len; r.gap = gap; r.expd = e;
    sbq.push_back(r);
  endtask

  task automatic set_core(input int k, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] d);
    bus_operation_in[2*k +: 2] = op;
    bus_address_in[32*k +: 32] = a;
    bus_data_in[32*k +: 32]    = d;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: each tenure (maximal run of one grant value) pops one expectation.
  initial begin : monitor
    exp_t       e;
    logic [3:0] cur_g;
    int         len;
    int         gap;
    cur_g = '0; len = 0; gap = -1;
    e = '{grant: '0, owner: '0, op: '0, addr: '0, data: '0, hit: '0, len: 0, gap: -1, expd: 1'b0};
    forever begin
      @(negedge clk);
      if (mon_in_ten && grant !== cur_g) begin
        chk("tenure_len", 32'(len), 32'(e.len));
        chk("tenure_expired", 32'(tenure_expired), 32'(e.expd));
        mon_in_ten = 1'b0;
        gap = 0;
      end
      if (!mon_in_ten && grant !== 4'b0000) begin
        if (sbq.size() == 0) begin
          chk("unexpected_grant", 32'(grant), 32'd0);
          e.len = -1; e.expd = 1'b0;
        end else begin
          e = sbq.pop_front();
          chk("grant", 32'(grant), 32'(e.grant));
          chk("owner_id", 32'(owner_id), 32'(e.owner));
          chk("op_bc", 32'(bus_operation_bc), 32'(e.op));
          chk("addr_bc", bus_address_bc, e.addr);
          chk("data_bc", bus_data_bc, e.data);
          chk("hit_bc", 32'(cache_hit_bc), 32'(e.hit));
          if (e.gap >= 0) chk("turnaround_gap", 32'(gap), 32'(e.gap));
        end
        mon_in_ten = 1'b1;
        cur_g = grant;
        len = 0;
      end
      if (mon_in_ten) len++;
      else if (gap >= 0) gap++;
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation did not complete, checks so far %0d", n_chk);
    $fatal(1);
  end

  initial begin : stim
    // Reset held low with two requesters pending.
    reset = 1'b0;
    req_core = 4'b0011;
    cache_hit_in = 4'b0000;
    set_core(0, 2'b00, 32'h0000_0020, 32'h0000_00D0);
    set_core(1, 2'b01, 32'h0000_0040, 32'h0000_00D1);
    set_core(2, 2'b00, 32'h0000_0300, 32'h0000_00D3);
    set_core(3, 2'b01, 32'h0000_0400, 32'h0000_00D4);
    push(4'b0001, 3'd0, 2'b00, 32'h20, 32'hD0, 4'b0000, 5, -1, 1'b0);
    push(4'b0010, 3'd1, 2'b01, 32'h40, 32'hD1, 4'b0000, 3, 1, 1'b0);
    repeat (3) begin
      tick(1);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_op_bc", 32'(bus_operation_bc), 32'd3);
    end
    chk("rst_addr_bc", bus_address_bc, 32'd0);
    chk("rst_data_bc", bus_data_bc, 32'd0);
    chk("rst_owner", 32'(owner_id), 32'd0);
    chk("rst_expired", 32'(tenure_expired), 32'd0);
    reset = 1'b1;
    #1;
    chk("release_grant", 32'(grant), 32'd0);
    tick(1);
    chk("grant_after_reset", 32'(grant), 32'b0001);
    // Core0 releases after 5 granted cycles; core1 waits throughout.
    tick(4);
    req_core = 4'b0010;
    tick(4);
    req_core = 4'b0000;
    tick(4);

    // Core1 BusRdX with hits from both cores.
    set_core(1, 2'b10, 32'h0000_0100, 32'h0000_00D2);
    cache_hit_in = 4'b0011;
    req_core = 4'b0010;
    push(4'b0010, 3'd1, 2'b10, 32'h100, 32'hD2, 4'b0001, 3, -1, 1'b0);
    tick(3);
    req_core = 4'b0000;
    tick(4);

    // Reset in the middle of core1's tenure.
    req_core = 4'b0010;
    push(4'b0010, 3'd1, 2'b10, 32'h100, 32'hD2, 4'b0001, 2, -1, 1'b0);
    tick(3);
    reset = 1'b0;
    req_core = 4'b1111;
    cache_hit_in = 4'b1111;
    #1;
    chk("mid_reset_grant", 32'(grant), 32'd0);
    chk("mid_reset_op_bc", 32'(bus_operation_bc), 32'd3);
    // All four request; each holds for 2 granted cycles -> 0,1,2,3,0.
    push(4'b0001, 3'd0, 2'b00, 32'h20,  32'hD0, 4'b1110, 2, -1, 1'b0);
    push(4'b0010, 3'd1, 2'b10, 32'h100, 32'hD2, 4'b1101, 2,  1, 1'b0);
    push(4'b0100, 3'd2, 2'b00, 32'h300, 32'hD3, 4'b1011, 2,  1, 1'b0);
    push(4'b1000, 3'd3, 2'b01, 32'h400, 32'hD4, 4'b0111, 2,  1, 1'b0);
    push(4'b0001, 3'd0, 2'b00, 32'h20,  32'hD0, 4'b1110, 2,  1, 1'b0);
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("rr_ptr_after_reset", 32'(grant), 32'b0001);
    tick(1); req_core = 4'b1110;
    tick(1); req_core = 4'b1111;
    tick(2); req_core = 4'b1101;
    tick(3); req_core = 4'b1001;
    tick(3); req_core = 4'b0001;
    tick(3); req_core = 4'b0000;
    tick(4);

    // Core0 holds its request well past MAX_TENURE while core1 waits.
    cache_hit_in = 4'b0000;
    req_core = 4'b0001;
`ifdef ARB_TIMEOUT_EN
    push(4'b0001, 3'd0, 2'b00, 32'h20,  32'hD0, 4'b0000, 16, -1, 1'b1);
    push(4'b0010, 3'd1, 2'b10, 32'h100, 32'hD2, 4'b0000,  8,  1, 1'b0);
`else
    push(4'b0001, 3'd0, 2'b00, 32'h20,  32'hD0, 4'b0000, 20, -1, 1'b0);
    push(4'b0010, 3'd1, 2'b10, 32'h100, 32'hD2, 4'b0000,  4,  1, 1'b0);
`endif
    tick(2);  req_core = 4'b0011;
    tick(18); req_core = 4'b0010;
    tick(5);  req_core = 4'b0000;
    tick(6);

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    chk("no_open_tenure", 32'(mon_in_ten), 32'd0);
    chk("final_grant", 32'(grant), 32'd0);
    chk("final_op_bc", 32'(bus_operation_bc), 32'd3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
